// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver: sync/filter, 11-bit frame decode, E0/F0 prefix folding
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync, data_sync;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall, data_s;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          parity_q;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;
    logic          frame_ok, frame_bad;
    logic          pend_ext, pend_brk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Filtered level only moves after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q   <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            filt_d <= filt_q;
            if (clk_sync[1] != filt_q) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_q   <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall        = filt_d & ~filt_q;
    assign data_s      = data_sync[1];
    assign timeout_hit = (state_q != IDLE) && !fall && (tmo_cnt == TMO_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Odd parity: data bits plus parity bit must XOR to 1
    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (state_q == STOP && fall) begin
            if (data_s && (^shift_q ^ parity_q)) frame_ok  = 1'b1;
            else                                 frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            if (state_q == IDLE || fall || timeout_hit) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 1'b1;
            if (fall) begin
                case (state_q)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {data_s, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity_q <= data_s;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keycode   <= 8'h00;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            pend_ext  <= 1'b0;
            pend_brk  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= frame_bad | timeout_hit;
            if (frame_bad || timeout_hit) begin
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
            end else if (frame_ok) begin
                if (shift_q == 8'hE0) begin
                    pend_ext <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    pend_brk <= 1'b1;
                end else begin
                    keycode   <= shift_q;
                    key_ext   <= pend_ext;
                    key_make  <= ~pend_brk;
                    key_valid <= 1'b1;
                    pend_ext  <= 1'b0;
                    pend_brk  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - scoreboard bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TMO        = 1000;
    localparam int HALF       = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       make;
        logic       ext;
    } ev_t;

    ev_t ev_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  m_ext = 0, m_brk = 0;

    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_make(key_make), .key_ext(key_ext),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid && frame_err) chk("strobe_overlap", 1, 0);
        else if (key_valid || frame_err) begin
            if (ev_q.size() == 0) begin
                chk("unexpected_strobe", {key_valid, frame_err}, 0);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                chk("event_kind", frame_err, e.is_err);
                if (!e.is_err && key_valid) begin
                    chk("keycode", keycode, e.code);
                    chk("key_make", key_make, e.make);
                    chk("key_ext", key_ext, e.ext);
                end
            end
        end
    end

    task automatic bit_out(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Bench-side model of prefix folding pushes the expected event up front
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nfalls);
        logic [10:0] f;
        logic        p;
        ev_t         e;
        p = ~^b ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        if (nfalls == 11) begin
            if (bad_par) begin
                e = '{1'b1, 8'h00, 1'b0, 1'b0};
                ev_q.push_back(e);
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0)     m_brk = 1;
            else begin
                e = '{1'b0, b, ~m_brk, m_ext};
                ev_q.push_back(e);
                m_ext = 0; m_brk = 0;
            end
        end
        for (int i = 0; i < nfalls; i++) bit_out(f[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    initial begin
        ev_t e;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_keycode", keycode, 8'h00);
        chk("rst_make", key_make, 0);
        chk("rst_ext", key_ext, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_err", frame_err, 0);
        @(posedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        send_frame(8'h1C, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'h6B, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h75, 0, 11);
        send_frame(8'h72, 0, 11);

        send_frame(8'h74, 1, 11);
        chk("hold_keycode", keycode, 8'h72);
        chk("hold_make", key_make, 1);
        chk("hold_ext", key_ext, 0);
        send_frame(8'h74, 0, 11);

        send_frame(8'hE0, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h6B, 0, 11);
        send_frame(8'hE1, 0, 11);

        e = '{1'b1, 8'h00, 1'b0, 1'b0};
        ev_q.push_back(e);
        m_ext = 0; m_brk = 0;
        send_frame(8'h1C, 0, 5);
        repeat (TMO + 10) @(posedge clk);
        chk("timeout_consumed", ev_q.size(), 0);
        send_frame(8'h1C, 0, 11);

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        send_frame(8'h29, 0, 11);

        send_frame(8'hE0, 0, 11);
        send_frame(8'h1C, 0, 5);
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_keycode", keycode, 8'h00);
        chk("midrst_make", key_make, 0);
        chk("midrst_ext", key_ext, 0);
        @(posedge clk);
        reset = 1'b0;
        m_ext = 0; m_brk = 0;
        repeat (20) @(posedge clk);
        send_frame(8'h6B, 0, 11);

        repeat (200) @(posedge clk);
        chk("queue_drained", ev_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
